// File: rtl/tdc_thermo_encoder_pkg.sv
// Shared constants for the fine TDC time-stamp path.
// Also holds the log2 helper used to check and size the encoder parameters.
package tdc_pkg;

  localparam int unsigned TDC_TAPS   = 1024;
  localparam int unsigned TDC_FINE_W = 10;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tdc_thermo_encoder_popcount_tree.sv
// Combinational population count built as a balanced binary adder tree.
// Each level splits the vector in half and sums the two narrower counts.
module popcount_tree
  import tdc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     bits,
  output logic [clog2(N):0] sum
);

  if (N == 1) begin : g_leaf
    assign sum = bits;
  end else begin : g_split
    localparam int unsigned H = N / 2;

    logic [clog2(H):0] lo_sum;
    logic [clog2(H):0] hi_sum;

    popcount_tree #(.N(H)) u_lo (
      .bits (bits[H-1:0]),
      .sum  (lo_sum)
    );

    popcount_tree #(.N(H)) u_hi (
      .bits (bits[N-1:H]),
      .sum  (hi_sum)
    );

    assign sum = {1'b0, lo_sum} + {1'b0, hi_sum};
  end

endmodule

// File: rtl/tdc_thermo_encoder.sv
// Thermometer-to-binary encoder for the fine TDC delay line.
// Two register stages: capture of the code, then saturated popcount with valid.
module tdc_thermo_encoder
  import tdc_pkg::*;
#(
  parameter int unsigned N = TDC_TAPS,
  parameter int unsigned W = TDC_FINE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         capture,
  input  logic [N-1:0] therm,
  output logic [W-1:0] count,
  output logic         sat,
  output logic         valid
);

  if ((N < 4) || (W != clog2(N)) || (N != (1 << W))) begin : g_param_check
    $error("tdc_thermo_encoder: N must be a power of 2 >= 4 and W = log2(N)");
  end

  logic [N-1:0] code_q;
  logic         s1_valid;
  logic [W:0]   ones;

  popcount_tree #(.N(N)) u_popcount (
    .bits (code_q),
    .sum  (ones)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q   <= '0;
      s1_valid <= 1'b0;
      count    <= '0;
      sat      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        code_q <= therm;
      end
      valid <= s1_valid;
      // A full chain needs W+1 bits, so it is clipped to the largest W-bit code.
      if (s1_valid) begin
        if (ones == (W + 1)'(N)) begin
          count <= '1;
          sat   <= 1'b1;
        end else begin
          count <= ones[W-1:0];
          sat   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// Randomised self-checking bench for tdc_thermo_encoder.
// Expected results come from a plain bit-count model and a queue of due outputs.
module tb_tdc_thermo_encoder;

  localparam int unsigned N = 1024;
  localparam int unsigned W = 10;

  typedef struct {
    int cyc_due;
    int cnt;
    int st;
  } pending_t;

  logic         clk;
  logic         reset;
  logic         capture;
  logic [N-1:0] therm;
  logic [W-1:0] count;
  logic         sat;
  logic         valid;

  int       checks;
  int       errors;
  int       cyc;
  int       last_cnt;
  int       last_sat;
  pending_t pending[$];

  tdc_thermo_encoder #(.N(N), .W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .capture (capture),
    .therm   (therm),
    .count   (count),
    .sat     (sat),
    .valid   (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks = checks + 1;
    if (obs != exp) begin
      errors = errors + 1;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] thermo(input int n);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int ones_of(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (v[i]) c++;
    return c;
  endfunction

  // One clock: apply inputs, advance the model, then check all outputs.
  task automatic step(input logic rst, input logic cap, input logic [N-1:0] t);
    pending_t p;
    int       exp_valid;
    reset   = rst;
    capture = cap;
    therm   = t;
    @(posedge clk);
    cyc = cyc + 1;
    exp_valid = 0;
    if (rst) begin
      pending.delete();
      last_cnt = 0;
      last_sat = 0;
    end else begin
      if (pending.size() > 0 && pending[0].cyc_due == cyc) begin
        p = pending.pop_front();
        exp_valid = 1;
        last_cnt  = p.cnt;
        last_sat  = p.st;
      end
      if (cap) begin
        p.cyc_due = cyc + 1;
        p.cnt     = ones_of(t);
        p.st      = 0;
        if (p.cnt == N) begin
          p.cnt = (1 << W) - 1;
          p.st  = 1;
        end
        pending.push_back(p);
      end
    end
    #1;
    chk("valid", int'(valid), exp_valid);
    chk("count", int'(count), last_cnt);
    chk("sat", int'(sat), last_sat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 1) ? '1 : '0);
  endtask

  initial begin
    logic [N-1:0] v;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    last_cnt = 0;
    last_sat = 0;
    reset    = 1'b1;
    capture  = 1'b0;
    therm    = '0;

    // Reset dominates a held capture of a full chain.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '1);
    idle(4);

    step(1'b0, 1'b1, thermo(300));
    idle(4);

    // Boundary codes.
    step(1'b0, 1'b1, '0);
    idle(3);
    step(1'b0, 1'b1, thermo(1));
    idle(3);
    step(1'b0, 1'b1, thermo(1023));
    idle(3);
    step(1'b0, 1'b1, '1);
    idle(3);

    v = thermo(100);
    v[50]  = 1'b0;
    v[101] = 1'b1;
    step(1'b0, 1'b1, v);
    idle(3);

    step(1'b0, 1'b1, thermo(5));
    step(1'b0, 1'b1, thermo(512));
    step(1'b0, 1'b1, thermo(1000));
    idle(4);

    // In-flight capture discarded by reset, then a clean capture.
    step(1'b0, 1'b1, thermo(700));
    step(1'b1, 1'b0, '0);
    idle(3);
    step(1'b0, 1'b1, thermo(42));
    idle(3);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
        1:       v = thermo(int'($urandom_range(0, N)));
        2: begin
          v = thermo(int'($urandom_range(0, N)));
          v[$urandom_range(0, N - 1)] ^= 1'b1;
        end
        default: v = $urandom_range(0, 1) ? '1 : thermo(N - 1);
      endcase
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, v);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
